nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder upstream of the team's 4-bit ripple adder vector_ripple_adder.
//  Accepts a full-width operand pair over a valid/ready handshake. Feeds one 4-bit slice per
//  clock into the ripple adder and registers the slice carry between cycles.
//  Presents the assembled sum and carry-out over a valid/ready handshake.
//  Trades latency for area in wide datapaths built from the shared 4-bit slice.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair a/b/cin is valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to slice 0
//  out_valid  out  1      sum/cout are valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of MSB slice
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, sum=0, cout=0, slice counter=0, carry reg=0;
//    in_ready=0 while rst high, 1 the first cycle after rst deasserts.
//  - in_ready = (state==IDLE) & ~rst (combinational); out_valid is high only in DONE.
//  - FSM, NIB = WIDTH/4:
//    IDLE: on in_valid&in_ready latch a, b into shift regs, carry<=cin, cnt<=0 -> RUN.
//    RUN: each cycle add low nibbles + carry. Shift the slice sum into result from MSB side.
//      Shift a/b right by 4, carry<=slice cout, cnt++. After the NIB-th slice -> DONE.
//    DONE: sum=result, cout=carry; both held stable until out_valid&out_ready -> IDLE.
//  - Latency: accept in cycle T, out_valid asserted in cycle T+NIB+1. WIDTH=4: exactly one RUN cycle.
//  - Not pipelined: one operation in flight. in_valid is ignored outside IDLE.
//    Peak throughput is one result per NIB+2 cycles (accept, NIB RUN, DONE handshake).
//  - in_valid/a/b/cin may change freely after acceptance; only the latched copies are used.
//  - sum/cout hold their last DONE values in IDLE and RUN. out_valid qualifies them.
//  - rst during RUN or DONE: the operation is abandoned, no out_valid, all registers return to reset values.
//  - rst wins over any simultaneous handshake in the same cycle.
// CONFIGURATION
//  NIBBLE_SUB_EN defined: adds input sub (1 bit, sampled with a/b) and output ovf (1 bit).
//    When sub=1: b is inverted at latch time and carry<=1 (cin ignored), giving sum = a - b.
//    When sub=0: the block adds as normal.
//    ovf = signed overflow of the final MSB slice (carry into bit WIDTH-1 XOR cout).
//    ovf is valid with out_valid, resets to 0 and is held like sum.
//  NIBBLE_SUB_EN undefined: no sub/ovf ports, addition only.
// STRUCTURE
//  nibble_add_pkg: NIB_W=4 constant, state_t enum {IDLE,RUN,DONE}, cnt width function clog2(WIDTH/4).
//  One sub-module: vector_ripple_adder instance as the per-cycle 4-bit datapath slice.
//    .d = carry reg, .c = slice cout.
//  Everything else (FSM, shift regs, counter) stays local to this module.
// TESTING
//  - WIDTH=16: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid exactly 5 cycles after accept.
//  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples across all 4 slices).
//  - a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
//  - Backpressure: out_ready=0 for 10 cycles in DONE -> sum/cout stable, in_ready=0,
//    in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
//  - rst asserted in 2nd RUN cycle -> out_valid never rises, sum=0, in_ready=1 cycle after rst drops.
//    A new 0x0001+0x0001 then gives 0x0002.
//  - NIBBLE_SUB_EN, WIDTH=16: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
//    sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
//  - Also run WIDTH=4 and WIDTH=32 with random operands against a behavioural a+b+cin model.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared constants and types for the nibble-serial adder.
// Holds the 4-bit slice width, the control state encoding and the counter sizing helper.
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count width/4 slices, never less than one bit.
    function automatic int cnt_w(input int width);
        int nib;
        int w;
        nib = width / NIB_W;
        w   = 0;
        while ((1 << w) < nib) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vector_ripple_adder.sv
// 4-bit ripple-carry adder slice.
// d is the carry into bit 0, c is the carry out of bit 3.
module vector_ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       d,
    output logic [3:0] s,
    output logic       c
);

    logic [4:0] carry;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = d;
        for (int i = 0; i < 4; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c = carry[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built from one shared 4-bit ripple slice.
// Operands are latched on a valid/ready handshake, one nibble is added per clock with the
// slice carry registered in between, and the assembled result is offered on valid/ready.
// Optional feature macro: NIBBLE_SUB_EN adds a sub input (a - b) and a signed ovf output.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high (unless rst)
//   RUN   | adding one nibble per cycle, NIB cycles in total
//   DONE  | result presented, out_valid high until out_ready
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    import nibble_add_pkg::*;

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = cnt_w(WIDTH);

    generate
        if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   b_eff;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               cin_eff;
    logic               accept;
    logic               last_slice;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_c;

    vector_ripple_adder u_slice (
        .a (a_sh[NIB_W-1:0]),
        .b (b_sh[NIB_W-1:0]),
        .d (carry_q),
        .s (slice_s),
        .c (slice_c)
    );

    // Operand conditioning at latch time: subtraction is a + ~b + 1.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef NIBBLE_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
    end

    assign accept     = in_valid & in_ready;
    assign last_slice = (state_q == RUN) && (cnt_q == CNT_W'(NIB - 1));
    // New slice sum enters from the MSB side so slice 0 lands at the LSB after NIB shifts.
    assign result_d   = (result_q >> NIB_W) | (WIDTH'(slice_s) << (WIDTH - NIB_W));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef NIBBLE_SUB_EN
    logic ovf_q;
    logic ovf_d;

    // Signed overflow: carry into the MSB of the top slice differs from its carry out.
    assign ovf_d = (a_sh[NIB_W-1] ^ b_sh[NIB_W-1] ^ slice_s[NIB_W-1]) ^ slice_c;
    assign ovf   = ovf_q;

    // Overflow flag captured with the final slice, held like sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last_slice) begin
            ovf_q <= ovf_d;
        end
    end
`endif

    // Operand shift registers, slice carry, counter and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= a;
                        b_sh    <= b_eff;
                        carry_q <= cin_eff;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh     <= a_sh >> NIB_W;
                    b_sh     <= b_sh >> NIB_W;
                    carry_q  <= slice_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    result_q <= result_d;
                    if (last_slice) begin
                        sum_q  <= result_d;
                        cout_q <= slice_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
